// File: rtl/pc_pkg.sv
// ============================================================================
// Module : pc_pkg
// Brief  : Shared state encoding and default widths for the PC fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    localparam int PC_W     = 8;
    localparam int PC_START = 0;

endpackage

`default_nettype wire

// File: rtl/pc_cycle_counter.sv
// ============================================================================
// Module : pc_cycle_counter
// Brief  : Saturating cycle counter with synchronous clear, async reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// Module : pc_fetch_ctrl
// Brief  : Program counter with start/done handshake, stall, halt and
//          absolute branch. Optional RUN-cycle counter under PC_CYCLE_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int D          = PC_W,
    parameter int START_ADDR = PC_START,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch,
    input  logic [D-1:0]     target,
    input  logic             halt,
    output logic [D-1:0]     prog_ctr,
    output logic             fetch_en,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [D-1:0] c_start_pc = D'(START_ADDR);

    pc_state_t    r_state;
    pc_state_t    w_state_next;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_pc_next;
    logic         r_done;
    logic         w_fetch_en;

    // Priority inside RUN: stall, then halt, then branch, then increment.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_fetch_en   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_pc_next    = c_start_pc;
                end
            end
            RUN: begin
                w_fetch_en = !stall;
                if (!stall) begin
                    if (halt) begin
                        w_state_next = DONE;
                    end else if (branch) begin
                        w_pc_next = target;
                    end else begin
                        w_pc_next = r_pc + D'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_pc_next    = c_start_pc;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= c_start_pc;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_done  <= (w_state_next == DONE);
        end
    end

    assign prog_ctr = r_pc;
    assign done     = r_done;
    assign fetch_en = w_fetch_en;

`ifdef PC_CYCLE_CNT_EN
    logic w_cnt_clr;
    logic w_cnt_inc;

    // Clear on the edge that enters RUN; count every edge spent in RUN.
    assign w_cnt_clr = start && (r_state != RUN);
    assign w_cnt_inc = (r_state == RUN);

    pc_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_cnt_inc),
        .cnt   (cycle_cnt)
    );
`else
    assign cycle_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
// Module : tb_pc_fetch_ctrl
// Brief  : Directed and randomized checks of pc_fetch_ctrl against a
//          behavioural model. Counter checks follow PC_CYCLE_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch;
    logic [7:0]  target;
    logic        halt;
    logic [7:0]  prog_ctr;
    logic        fetch_en;
    logic        done;
    logic [15:0] cycle_cnt;

    int checks = 0;
    int passes = 0;

    // Behavioural model: running flag, done flag, PC and RUN-edge count.
    bit m_run;
    bit m_done;
    int m_pc;
    int m_cnt;

    pc_fetch_ctrl #(
        .D          (8),
        .START_ADDR (0),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .branch    (branch),
        .target    (target),
        .halt      (halt),
        .prog_ctr  (prog_ctr),
        .fetch_en  (fetch_en),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt();
`ifdef PC_CYCLE_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_pc   = 0;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (!m_run) begin
            if (start) begin
                m_run  = 1'b1;
                m_done = 1'b0;
                m_pc   = 0;
                m_cnt  = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (!stall) begin
                if (halt) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end else if (branch) begin
                    m_pc = int'(target);
                end else begin
                    m_pc = (m_pc + 1) % 256;
                end
            end
        end
    endtask

    task automatic set_in(input bit s, input bit st, input bit br, input int tg, input bit h);
        start  = s;
        stall  = st;
        branch = br;
        target = 8'(tg);
        halt   = h;
    endtask

    // Advance one edge, update the model, land 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        #3;
        checks++;
        if (prog_ctr !== 8'd0) $display("FAIL reset_pc: got %0d want 0", prog_ctr); else passes++;
        checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passes++;
        checks++;
        if (fetch_en !== 1'b0) $display("FAIL reset_fetch_en: got %0b want 0", fetch_en); else passes++;
        checks++;
        if (cycle_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", cycle_cnt); else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        // One idle edge without start: must stay at START_ADDR.
        tick();
        checks++;
        if (prog_ctr !== 8'd0 || done !== 1'b0) $display("FAIL idle_hold: pc %0d done %0b want 0 0", prog_ctr, done); else passes++;
    endtask

    typedef struct {
        bit s;
        bit st;
        bit br;
        int tg;
        bit h;
        int fe;
        int pc;
        int dn;
    } vec_t;

    task automatic test_sequence();
        vec_t seq [18];
        seq = '{
            '{1, 0, 0, 0, 0, 0, 0, 0},   // start from IDLE
            '{0, 0, 0, 0, 0, 1, 1, 0},
            '{0, 0, 0, 0, 0, 1, 2, 0},
            '{0, 0, 0, 0, 0, 1, 3, 0},
            '{0, 0, 1, 8, 0, 1, 8, 0},   // absolute branch to 8
            '{0, 0, 0, 0, 0, 1, 9, 0},
            '{0, 0, 1, 4, 0, 1, 4, 0},   // absolute, not pc+4
            '{0, 0, 0, 0, 0, 1, 5, 0},
            '{0, 1, 1, 8, 0, 0, 5, 0},   // stall swallows branch
            '{0, 1, 1, 8, 0, 0, 5, 0},
            '{0, 0, 0, 0, 0, 1, 6, 0},
            '{0, 0, 0, 0, 0, 1, 7, 0},
            '{0, 0, 0, 0, 0, 1, 8, 0},
            '{0, 0, 1, 4, 1, 1, 8, 1},   // halt beats branch
            '{0, 0, 0, 0, 0, 0, 8, 1},
            '{1, 0, 0, 0, 0, 0, 0, 0},   // restart from DONE
            '{0, 0, 0, 0, 0, 1, 1, 0},
            '{1, 0, 0, 0, 0, 1, 2, 0}    // start ignored in RUN
        };
        for (int i = 0; i < 18; i++) begin
            set_in(seq[i].s, seq[i].st, seq[i].br, seq[i].tg, seq[i].h);
            #1;
            checks++;
            if (fetch_en !== 1'(seq[i].fe)) $display("FAIL seq_fetch_en[%0d]: got %0b want %0d", i, fetch_en, seq[i].fe); else passes++;
            tick();
            checks++;
            if (prog_ctr !== 8'(seq[i].pc)) $display("FAIL seq_pc[%0d]: got %0d want %0d", i, prog_ctr, seq[i].pc); else passes++;
            checks++;
            if (done !== 1'(seq[i].dn)) $display("FAIL seq_done[%0d]: got %0b want %0d", i, done, seq[i].dn); else passes++;
            checks++;
            if (cycle_cnt !== 16'(exp_cnt())) $display("FAIL seq_cnt[%0d]: got %0d want %0d", i, cycle_cnt, exp_cnt()); else passes++;
        end
    endtask

    task automatic test_wrap();
        set_in(0, 0, 1, 255, 0);
        tick();
        checks++;
        if (prog_ctr !== 8'd255) $display("FAIL wrap_branch: got %0d want 255", prog_ctr); else passes++;
        set_in(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (prog_ctr !== 8'd0 || done !== 1'b0) $display("FAIL wrap_pc: pc %0d done %0b want 0 0", prog_ctr, done); else passes++;
        checks++;
        if (fetch_en !== 1'b1) $display("FAIL wrap_fetch_en: got %0b want 1", fetch_en); else passes++;
    endtask

    task automatic test_reset_mid_run();
        set_in(0, 0, 1, 7, 0);
        tick();
        checks++;
        if (prog_ctr !== 8'd7) $display("FAIL midrst_pre_pc: got %0d want 7", prog_ctr); else passes++;
        set_in(0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (prog_ctr !== 8'd0 || done !== 1'b0 || fetch_en !== 1'b0)
            $display("FAIL midrst_async: pc %0d done %0b fetch_en %0b want 0 0 0", prog_ctr, done, fetch_en);
        else passes++;
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (prog_ctr !== 8'd0 || fetch_en !== 1'b0) $display("FAIL midrst_idle: pc %0d fetch_en %0b want 0 0", prog_ctr, fetch_en); else passes++;
    endtask

    task automatic test_cycle_cnt();
        int want;
        set_in(1, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            set_in(0, (i == 3 || i == 6), 0, 0, (i == 10));
            tick();
        end
`ifdef PC_CYCLE_CNT_EN
        want = 10;
`else
        want = 0;
`endif
        checks++;
        if (cycle_cnt !== 16'(want)) $display("FAIL cnt_run: got %0d want %0d", cycle_cnt, want); else passes++;
        checks++;
        if (done !== 1'b1 || prog_ctr !== 8'd7) $display("FAIL cnt_halt: done %0b pc %0d want 1 7", done, prog_ctr); else passes++;
        set_in(0, 0, 0, 0, 0);
        repeat (3) tick();
        checks++;
        if (cycle_cnt !== 16'(want)) $display("FAIL cnt_hold: got %0d want %0d", cycle_cnt, want); else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(99) < 15, $urandom_range(99) < 20, $urandom_range(99) < 25,
                   int'($urandom_range(255)), $urandom_range(99) < 6);
            #1;
            checks++;
            if (fetch_en !== (m_run && !stall)) $display("FAIL rnd_fetch_en[%0d]: got %0b want %0b", i, fetch_en, m_run && !stall); else passes++;
            tick();
            checks++;
            if (prog_ctr !== 8'(m_pc)) $display("FAIL rnd_pc[%0d]: got %0d want %0d", i, prog_ctr, m_pc); else passes++;
            checks++;
            if (done !== m_done) $display("FAIL rnd_done[%0d]: got %0b want %0b", i, done, m_done); else passes++;
            checks++;
            if (cycle_cnt !== 16'(exp_cnt())) $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, cycle_cnt, exp_cnt()); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_reset_mid_run();
        test_cycle_cnt();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d so far", passes, checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
